ticket_dispatcher: RTL and testbench
====================================

# ticket_dispatcher

- Sequencing controller for the queue-number response system.
- Issues ticket numbers on customer button presses and keeps a count of waiting customers.
- Arbitrates waiting tickets onto five service counters, A–E, and announces each call.
- Sits between the button input and the per-counter service-number displays, replacing free-running call logic with a busy/done handshake per counter.

## Interface
Parameters:
- ANNOUNCE_CYCLES, 2: cycles a call is held on counter_call/number_service before the next dispatch (≥1).
- QUEUE_MAX, 63: maximum waiting tickets; further presses are rejected.

Ports (one clock `clk`; reset `rst` is asynchronous, active-high):
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- button  in  1  customer ticket request; synchronous, held ≥1 cycle per press.
- counter_done  in  5  bit i = counter i (0=A … 4=E) finished serving; 1-cycle pulse.
- current_number  out  6  last issued ticket number (0 = none issued yet).
- number_service  out  6  ticket number most recently called.
- counter_call  out  3  index of counter being called (0–4); 3'b111 when no call is being announced.
- call_valid  out  1  high for exactly one cycle when a new call is made.
- counter_busy  out  5  bit i high while counter i is serving.
- service_numbers  out  30  packed per-counter ticket being served: [6i+5:6i] = counter i.
- waiting  out  6  tickets issued but not yet called.
- full  out  1  waiting == QUEUE_MAX.

## Operation
- Press detection: registered copy `button_q`; a press is `button & ~button_q` at a rising edge.
  - Accepted if `!full`: current_number advances 1→2→…→63→1 (0 is skipped after the first ticket); waiting increments.
  - Rejected if `full`: no change.
- Counter release: counter_done[i] with counter_busy[i]=1 clears busy[i] at that edge. service_numbers keeps its last value.
  - counter_done on an idle counter is ignored.
- FSM, three states:
  - IDLE: if waiting>0 and any counter is free (busy==0 at cycle start) → GRANT; else stay.
  - GRANT: choose counter k per priority (see Configuration). At the exiting edge:
    - number_service advances with the same 63→1 wrap, starting from 0, so the first call is 1;
    - service_numbers[k] ← new number_service; busy[k]←1; counter_call←k; call_valid←1; waiting decrements;
    - go to ANNOUNCE.
  - ANNOUNCE: hold counter_call/number_service for ANNOUNCE_CYCLES cycles, then counter_call←3'b111 and → IDLE.
  - If all counters become busy in GRANT, return to IDLE without a call. This cannot occur because release only frees counters, but it is required for robustness.
- Accepted press and dispatch on the same edge: waiting unchanged.
- Done and GRANT in the same cycle on the same counter: the counter is not eligible that cycle, because eligibility is sampled at cycle start; it becomes eligible next cycle.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); pending waiting count is discarded.

## Timing
- Reset values:
  - current_number=0, number_service=0, counter_call=3'b111, call_valid=0;
  - counter_busy=0, service_numbers=0, waiting=0, full=0;
  - FSM=IDLE, button_q=0.
- Press at edge N → current_number/waiting updated at edge N (visible after N).
- Earliest call: IDLE sees waiting>0 at edge N+1 → GRANT; call_valid high after edge N+2. Total press-to-call latency is 2 cycles.
- Minimum spacing between calls: ANNOUNCE_CYCLES + 2 cycles.
- full is combinational from waiting.

## Configuration
- `DISPATCH_ROUND_ROBIN_EN`
  - Defined: rotating priority. The search starts at the counter after the last granted one (after reset, the search starts at A) and wraps E→A.
  - Undefined: fixed priority; the lowest-index free counter wins (A highest, E lowest).
  - Interface is identical in both builds.

## Test plan
- Reset then idle.
  - Stimulus: rst 1→0, no presses for 20 cycles.
  - Response: all outputs at reset values, counter_call=3'b111, no call_valid.
- Single press.
  - Stimulus: one 1-cycle button pulse.
  - Response: current_number=1 and waiting=1. Two cycles later call_valid pulses with counter_call=0 and number_service=1; service_numbers[5:0]=1, busy=5'b00001, waiting=0.
- Six rapid presses with no counter_done.
  - Response: tickets 1–5 go to counters A–E. Ticket 6 stays waiting (waiting=1) until counter_done[2] pulses.
  - Then ticket 6 goes to C (C is the only free counter) and service_numbers[17:12]=6.
- Priority.
  - Stimulus: fill A–E, pulse counter_done=5'b10001, press twice.
  - Response with `DISPATCH_ROUND_ROBIN_EN`: calls go to E then A.
  - Response without it: calls go to A then E.
- Full and wrap.
  - Stimulus: hold all counters busy and press until full.
  - Response: waiting=63, full=1; the next press leaves current_number unchanged.
  - Continue by issuing tickets up to 63; the next ticket is numbered 1, not 0.
- Reset mid-ANNOUNCE.
  - Stimulus: assert rst during the announce window.
  - Response: outputs return to reset values immediately, and the first ticket after release is 1.

Source files
------------

// File: rtl/ticket_dispatcher.sv
// ticket_dispatcher
//
// Sequencing controller for the queue-number response system. Issues ticket
// numbers on customer button presses, counts waiting customers, and dispatches
// waiting tickets onto five service counters (A..E) using a busy/done
// handshake. Each call is announced on counter_call/number_service for
// ANNOUNCE_CYCLES cycles.
//
// Build option:
//   DISPATCH_ROUND_ROBIN_EN  defined   -> rotating counter priority; the search
//                                         starts after the last granted counter
//                                         (A after reset) and wraps E->A.
//                            undefined -> fixed priority, A highest, E lowest.
//
// Parameters:
//   ANNOUNCE_CYCLES  cycles a call is held before the next dispatch (1..256)
//   QUEUE_MAX        maximum number of waiting tickets (1..63)
//
// Ports:
//   clk              in   system clock, rising edge
//   rst              in   asynchronous active-high reset
//   button           in   customer ticket request (edge detected)
//   counter_done     in   [4:0] per-counter service-finished pulse
//   current_number   out  [5:0] last issued ticket number (0 = none yet)
//   number_service   out  [5:0] ticket number most recently called
//   counter_call     out  [2:0] counter being announced, 3'b111 when none
//   call_valid       out  one-cycle pulse per new call
//   counter_busy     out  [4:0] per-counter serving flag
//   service_numbers  out  [29:0] ticket served by counter i at [6i+5:6i]
//   waiting          out  [5:0] tickets issued but not yet called
//   full             out  waiting == QUEUE_MAX (combinational)
`timescale 1ns/1ps

module ticket_dispatcher #(
  parameter int ANNOUNCE_CYCLES = 2,
  parameter int QUEUE_MAX       = 63
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        button,
  input  logic [4:0]  counter_done,
  output logic [5:0]  current_number,
  output logic [5:0]  number_service,
  output logic [2:0]  counter_call,
  output logic        call_valid,
  output logic [4:0]  counter_busy,
  output logic [29:0] service_numbers,
  output logic [5:0]  waiting,
  output logic        full
);

  localparam int         NUM_COUNTERS = 5;
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_GRANT     = 2'd1;
  localparam logic [1:0] ST_ANNOUNCE  = 2'd2;
  localparam logic [2:0] CALL_NONE    = 3'b111;
  localparam logic [5:0] NUM_MAX      = 6'd63;
  localparam logic [5:0] QMAX         = 6'(QUEUE_MAX);
  localparam logic [7:0] ANN_LAST     = 8'(ANNOUNCE_CYCLES - 1);

  // Ticket numbers run 1..63 and wrap back to 1; 0 only means "none yet".
  function automatic logic [5:0] next_num(input logic [5:0] n);
    next_num = (n == NUM_MAX) ? 6'd1 : (n + 6'd1);
  endfunction

`ifdef DISPATCH_ROUND_ROBIN_EN
  // First free counter found scanning upward from 'start', wrapping E->A.
  function automatic logic [2:0] pick_counter(input logic [4:0] free,
                                               input logic [2:0] start);
    logic [2:0] idx;
    logic       found;
    pick_counter = CALL_NONE;
    found        = 1'b0;
    idx          = start;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      if (free[idx] && !found) begin
        pick_counter = idx;
        found        = 1'b1;
      end else begin
        found = found;
      end
      idx = (idx == 3'd4) ? 3'd0 : (idx + 3'd1);
    end
  endfunction
`else
  // Lowest-index free counter; scanning downward lets A overwrite the rest.
  function automatic logic [2:0] pick_counter(input logic [4:0] free);
    pick_counter = CALL_NONE;
    for (int i = NUM_COUNTERS - 1; i >= 0; i--) begin
      pick_counter = free[i] ? 3'(i) : pick_counter;
    end
  endfunction
`endif

  logic [1:0]  state_q, state_d;
  logic        button_q;
  logic [5:0]  current_q, current_d;
  logic [5:0]  ns_q, ns_d;
  logic [2:0]  call_q, call_d;
  logic        call_valid_q, call_valid_d;
  logic [4:0]  busy_q, busy_d;
  logic [29:0] sn_q, sn_d;
  logic [5:0]  waiting_q, waiting_d;
  logic [7:0]  ann_cnt_q, ann_cnt_d;

  logic        press_s;
  logic        accept_s;
  logic        dispatch_s;
  logic [4:0]  free_s;
  logic [4:0]  busy_set_s;
  logic [2:0]  grant_idx_s;
  logic [5:0]  ns_next_s;

`ifdef DISPATCH_ROUND_ROBIN_EN
  logic [2:0]  rr_ptr_q, rr_ptr_d;
`endif

  // Next-state logic: press acceptance, FSM sequencing and dispatch bookkeeping.
  always_comb begin
    press_s      = button & ~button_q;
    accept_s     = press_s & ~full;
    // Eligibility uses busy at cycle start; a same-cycle done is seen next cycle.
    free_s       = ~busy_q;
`ifdef DISPATCH_ROUND_ROBIN_EN
    grant_idx_s  = pick_counter(free_s, rr_ptr_q);
    rr_ptr_d     = rr_ptr_q;
`else
    grant_idx_s  = pick_counter(free_s);
`endif
    ns_next_s    = next_num(ns_q);
    dispatch_s   = 1'b0;
    state_d      = state_q;
    call_d       = call_q;
    ann_cnt_d    = ann_cnt_q;
    ns_d         = ns_q;

    case (state_q)
      ST_IDLE: begin
        if ((waiting_q != 6'd0) && (free_s != 5'd0)) begin
          state_d = ST_GRANT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        // The no-free-counter branch is unreachable today but kept as a safe exit.
        if ((waiting_q != 6'd0) && (free_s != 5'd0)) begin
          dispatch_s = 1'b1;
          state_d    = ST_ANNOUNCE;
          call_d     = grant_idx_s;
          ns_d       = ns_next_s;
          ann_cnt_d  = 8'd0;
`ifdef DISPATCH_ROUND_ROBIN_EN
          rr_ptr_d   = (grant_idx_s == 3'd4) ? 3'd0 : (grant_idx_s + 3'd1);
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ANNOUNCE: begin
        if (ann_cnt_q == ANN_LAST) begin
          state_d   = ST_IDLE;
          call_d    = CALL_NONE;
          ann_cnt_d = 8'd0;
        end else begin
          ann_cnt_d = ann_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        call_d    = CALL_NONE;
        ann_cnt_d = 8'd0;
      end
    endcase

    for (int i = 0; i < NUM_COUNTERS; i++) begin
      busy_set_s[i]  = dispatch_s && (grant_idx_s == 3'(i));
      sn_d[6*i +: 6] = busy_set_s[i] ? ns_next_s : sn_q[6*i +: 6];
    end

    // Done on an idle counter is a no-op because clearing an already-clear bit.
    busy_d       = (busy_q & ~counter_done) | busy_set_s;
    call_valid_d = dispatch_s;
    current_d    = accept_s ? next_num(current_q) : current_q;

    case ({accept_s, dispatch_s})
      2'b10:   waiting_d = waiting_q + 6'd1;
      2'b01:   waiting_d = waiting_q - 6'd1;
      default: waiting_d = waiting_q;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      button_q     <= 1'b0;
      current_q    <= 6'd0;
      ns_q         <= 6'd0;
      call_q       <= CALL_NONE;
      call_valid_q <= 1'b0;
      busy_q       <= 5'd0;
      sn_q         <= 30'd0;
      waiting_q    <= 6'd0;
      ann_cnt_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      button_q     <= button;
      current_q    <= current_d;
      ns_q         <= ns_d;
      call_q       <= call_d;
      call_valid_q <= call_valid_d;
      busy_q       <= busy_d;
      sn_q         <= sn_d;
      waiting_q    <= waiting_d;
      ann_cnt_q    <= ann_cnt_d;
    end
  end

`ifdef DISPATCH_ROUND_ROBIN_EN
  // Rotating-priority search start; A after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= 3'd0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

  assign current_number  = current_q;
  assign number_service  = ns_q;
  assign counter_call    = call_q;
  assign call_valid      = call_valid_q;
  assign counter_busy    = busy_q;
  assign service_numbers = sn_q;
  assign waiting         = waiting_q;
  assign full            = (waiting_q == QMAX);

endmodule

// File: tb/tb_ticket_dispatcher.sv
`timescale 1ns/1ps

module tb_ticket_dispatcher;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        button = 1'b0;
  logic [4:0]  counter_done = 5'd0;
  logic [5:0]  current_number;
  logic [5:0]  number_service;
  logic [2:0]  counter_call;
  logic        call_valid;
  logic [4:0]  counter_busy;
  logic [29:0] service_numbers;
  logic [5:0]  waiting;
  logic        full;

  ticket_dispatcher #(.ANNOUNCE_CYCLES(2), .QUEUE_MAX(63)) dut (
    .clk(clk), .rst(rst), .button(button), .counter_done(counter_done),
    .current_number(current_number), .number_service(number_service),
    .counter_call(counter_call), .call_valid(call_valid),
    .counter_busy(counter_busy), .service_numbers(service_numbers),
    .waiting(waiting), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] ctr;
    logic [5:0] num;
  } call_t;

  call_t sb[$];
  int    checks = 0;
  int    errors = 0;
  logic [5:0] exp_cur;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_call(input logic [2:0] c, input logic [5:0] n);
    call_t e;
    e.ctr = c;
    e.num = n;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press();
    button = 1'b1;
    @(negedge clk);
    button = 1'b0;
    @(negedge clk);
  endtask

  task automatic done_pulse(input logic [4:0] m);
    counter_done = m;
    @(negedge clk);
    counter_done = 5'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_cur"},   current_number, 32'd0);
    check({tag, "_ns"},    number_service, 32'd0);
    check({tag, "_call"},  counter_call, 32'd7);
    check({tag, "_cv"},    call_valid, 32'd0);
    check({tag, "_busy"},  counter_busy, 32'd0);
    check({tag, "_sn"},    service_numbers, 32'd0);
    check({tag, "_wait"},  waiting, 32'd0);
    check({tag, "_full"},  full, 32'd0);
  endtask

  // Wait (bounded) until every expected call has been observed.
  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drain_pending"}, sb.size(), 32'd0);
    sb.delete();
    tick(6);
  endtask

  // Monitor: every call_valid pulse must match the next expected call.
  initial begin
    call_t       e;
    logic [29:0] sh;
    forever begin
      @(negedge clk);
      if (!rst && call_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_call: counter %0d number %0d, expected no call", counter_call, number_service);
        end else begin
          e  = sb.pop_front();
          sh = service_numbers >> (6 * int'(e.ctr));
          check("call_counter", counter_call, e.ctr);
          check("call_number", number_service, e.num);
          check("call_slot", sh[5:0], e.num);
          check("call_busy", counter_busy[e.ctr], 32'd1);
        end
      end
    end
  end

  initial begin
    int n;
    // Reset then idle
    tick(2);
    rst = 1'b0;
    check_reset("rst0");
    tick(20);
    check_reset("idle20");

    // Single press: latency 2 cycles, counter A
    do_reset();
    button = 1'b1;
    @(negedge clk);
    button = 1'b0;
    push_call(3'd0, 6'd1);
    check("p1_cur", current_number, 32'd1);
    check("p1_wait", waiting, 32'd1);
    check("p1_cv0", call_valid, 32'd0);
    @(negedge clk);
    check("p1_cv1", call_valid, 32'd0);
    @(negedge clk);
    check("p1_cv2", call_valid, 32'd1);
    check("p1_busy", counter_busy, 32'h01);
    check("p1_waitafter", waiting, 32'd0);
    check("p1_snA", service_numbers[5:0], 32'd1);
    drain("p1");
    check("p1_callnone", counter_call, 32'd7);

    // Six rapid presses: 1..5 to A..E, 6 waits for C
    do_reset();
    for (int i = 0; i < 5; i++) push_call(3'(i), 6'(i + 1));
    repeat (6) press();
    drain("six");
    check("six_busy", counter_busy, 32'h1f);
    check("six_wait", waiting, 32'd1);
    check("six_cur", current_number, 32'd6);
    check("six_full", full, 32'd0);
    push_call(3'd2, 6'd6);
    done_pulse(5'b00100);
    drain("six_c");
    check("six_snC", service_numbers[17:12], 32'd6);
    check("six_wait0", waiting, 32'd0);
    check("six_busy2", counter_busy, 32'h1f);

    // Priority: free A and E, two presses
`ifdef DISPATCH_ROUND_ROBIN_EN
    push_call(3'd4, 6'd7);
    push_call(3'd0, 6'd8);
`else
    push_call(3'd0, 6'd7);
    push_call(3'd4, 6'd8);
`endif
    done_pulse(5'b10001);
    press();
    press();
    drain("prio");
    check("prio_busy", counter_busy, 32'h1f);
    check("prio_cur", current_number, 32'd8);
    check("prio_wait", waiting, 32'd0);

    // Full and wrap: all counters busy, 63 accepted presses then a rejected one
    exp_cur = 6'd8;
    for (int i = 0; i < 63; i++) begin
      press();
      exp_cur = (exp_cur == 6'd63) ? 6'd1 : (exp_cur + 6'd1);
      check("fill_cur", current_number, exp_cur);
    end
    check("fill_wait", waiting, 32'd63);
    check("fill_full", full, 32'd1);
    press();
    check("rej_cur", current_number, exp_cur);
    check("rej_wait", waiting, 32'd63);
    check("rej_full", full, 32'd1);

    // Free A: next call is number 9 and full drops
    push_call(3'd0, 6'd9);
    done_pulse(5'b00001);
    n = 0;
    while (!call_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("full_call_seen", call_valid, 32'd1);
    check("full_wait62", waiting, 32'd62);
    check("full_drop", full, 32'd0);

    // Reset mid-ANNOUNCE: outputs clear without a clock edge
    #2;
    rst = 1'b1;
    #1;
    check_reset("midrst");
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    check_reset("postrst");
    push_call(3'd0, 6'd1);
    press();
    check("postrst_cur", current_number, 32'd1);
    drain("postrst");
    check("postrst_busy", counter_busy, 32'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
